// File: rtl/ext_device.sv
// Upstream I/O device model: fills a LENGTH-word block at a fixed rate, raises a
// one-cycle interrupt when the block is complete, then serves it as 4-word bursts.
module ext_device #(
  parameter int          WORD_SIZE     = 16,
  parameter int          LENGTH        = 12,
  parameter int          FILL_INTERVAL = 4,
  parameter logic [15:0] DATA_BASE     = 16'h0000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_read_en,
  input  logic [1:0]             i_offset,
  input  logic                   i_dma_end,
  output logic [4*WORD_SIZE-1:0] o_edata,
  output logic                   o_dev_interrupt,
  output logic                   o_ready,
  output logic [7:0]             o_xfer_count
);

  localparam int NBURST = LENGTH / 4;
  localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int WIW    = $clog2(LENGTH + 1);
  localparam int IW     = (FILL_INTERVAL > 1) ? $clog2(FILL_INTERVAL) : 1;
  localparam logic [IW-1:0]  LAST_INT  = IW'(FILL_INTERVAL - 1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(LENGTH - 1);

  typedef enum logic [1:0] {S_FILL, S_READY, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIW-1:0]        r_word_idx;
  logic [IW-1:0]         r_interval;
  logic [15:0]           r_gcount;
  logic [7:0]            r_xfer_count;
  logic                  r_irq;
  logic [WORD_SIZE-1:0]  r_buf [LENGTH];

  logic                  w_tick;
  logic                  w_last;
  logic                  w_rearm;
  logic                  w_present;
  logic [1:0]            w_sel;
  logic [AW-1:0]         w_base;

  assign w_tick  = (r_state == S_FILL) && (r_interval == LAST_INT);
  assign w_last  = (r_word_idx == LAST_WORD);
  assign w_rearm = (r_state != S_FILL) && i_dma_end;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_tick && w_last) w_state_next = S_READY;
      // dma_end takes priority over a simultaneous read_en
      S_READY: if (i_dma_end) w_state_next = S_FILL;
               else if (i_read_en) w_state_next = S_DRAIN;
      S_DRAIN: if (i_dma_end) w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_FILL;
      r_word_idx   <= '0;
      r_interval   <= '0;
      r_gcount     <= '0;
      r_xfer_count <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_irq   <= w_tick && w_last;
      if (w_rearm) begin
        r_word_idx   <= '0;
        r_interval   <= '0;
        r_xfer_count <= r_xfer_count + 8'd1;
      end else if (r_state == S_FILL) begin
        if (w_tick) begin
          r_interval <= '0;
          r_word_idx <= r_word_idx + WIW'(1);
          r_gcount   <= r_gcount + 16'd1;
        end else begin
          r_interval <= r_interval + IW'(1);
        end
      end
    end
  end

  // Buffer is deliberately not reset; it is only presented outside FILL.
  always_ff @(posedge i_clk) begin
    if (w_tick) r_buf[r_word_idx[AW-1:0]] <= WORD_SIZE'(DATA_BASE + r_gcount);
  end

  assign w_present = i_read_en && (r_state != S_FILL) && (int'(i_offset) < NBURST);
  assign w_sel     = w_present ? i_offset : 2'd0;
  assign w_base    = AW'({w_sel, 2'b00});

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_burst
      assign o_edata[gi*WORD_SIZE +: WORD_SIZE] =
        w_present ? r_buf[w_base + AW'(gi)] : '0;
    end
  endgenerate

  assign o_dev_interrupt = r_irq;
  assign o_ready         = (r_state != S_FILL);
  assign o_xfer_count    = r_xfer_count;

endmodule

// File: tb/tb_ext_device.sv
// Self-checking bench for ext_device: default instance plus a DATA_BASE=FFFE
// instance, compared against an arithmetic model of block contents and timing.
module tb_ext_device;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, ren0, dend0;
  logic [1:0]  off0;
  logic [63:0] ed0;
  logic        irq0, rdy0;
  logic [7:0]  xc0;

  logic        rst1, ren1, dend1;
  logic [1:0]  off1;
  logic [63:0] ed1;
  logic        irq1, rdy1;
  logic [7:0]  xc1;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_gbase0, m_gbase1;
  logic [7:0]  m_xfer0;

  ext_device dut0 (
    .i_clk(clk), .i_reset(rst0), .i_read_en(ren0), .i_offset(off0), .i_dma_end(dend0),
    .o_edata(ed0), .o_dev_interrupt(irq0), .o_ready(rdy0), .o_xfer_count(xc0)
  );

  ext_device #(.DATA_BASE(16'hFFFE)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_read_en(ren1), .i_offset(off1), .i_dma_end(dend1),
    .o_edata(ed1), .o_dev_interrupt(irq1), .o_ready(rdy1), .o_xfer_count(xc1)
  );

  // Burst k of a block whose first word has global index gstart.
  function automatic logic [63:0] exp_burst(input logic [15:0] base, input logic [15:0] gstart,
                                            input int off);
    logic [63:0] r;
    logic [15:0] w;
    r = '0;
    if (off < 3) begin
      for (int k = 0; k < 4; k++) begin
        w = base + gstart + 16'(4 * off + k);
        r[16*k +: 16] = w;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int which, input int expect_n, input int pulse_at,
                            input string name);
    int got;
    got = -1;
    for (int n = 1; n <= 200; n++) begin
      if (which == 1) dend1 = (n == pulse_at);
      else            dend0 = (n == pulse_at);
      step();
      if (which == 1) dend1 = 1'b0;
      else            dend0 = 1'b0;
      if (((which == 1) ? rdy1 : rdy0) === 1'b1) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != expect_n) begin
      errors++;
      $display("FAIL %s: ready after %0d posedges, expected %0d", name, got, expect_n);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; ren0 = 1'b1; off0 = 2'd0; dend0 = 1'b0;
    repeat (3) step();
    checks++; if (ed0 !== 64'd0) begin errors++; $display("FAIL reset_edata: got %h expected 0", ed0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
    checks++; if (xc0 !== 8'd0) begin errors++; $display("FAIL reset_xfer: got %0d expected 0", xc0); end
    ren0 = 1'b0;
    rst0 = 1'b0;
    m_gbase0 = 16'd0;
    m_xfer0  = 8'd0;
    $display("reset released");
  endtask

  task automatic test_fill_timing();
    wait_ready(0, 48, 0, "first_fill");
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq0); end
    checks++; if (ed0 !== 64'd0) begin errors++; $display("FAIL ready_noread_edata: got %h expected 0", ed0); end
    step();
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ready_hold: got %b expected 1", rdy0); end
    $display("fill timing: ready at posedge 48, irq one cycle");
  endtask

  task automatic test_bursts();
    logic [63:0] table_v [4];
    logic [63:0] e;
    table_v[0] = 64'h0003_0002_0001_0000;
    table_v[1] = 64'h0007_0006_0005_0004;
    table_v[2] = 64'h000B_000A_0009_0008;
    table_v[3] = 64'h0;
    ren0 = 1'b1;
    for (int o = 0; o < 4; o++) begin
      off0 = 2'(o);
      #1;
      checks++;
      if (ed0 !== table_v[o]) begin
        errors++; $display("FAIL burst_const off=%0d: got %h expected %h", o, ed0, table_v[o]);
      end
      $display("burst offset %0d edata %h", o, ed0);
    end
    step();
    ren0 = 1'b0; off0 = 2'd1; #1;
    checks++; if (ed0 !== 64'd0) begin errors++; $display("FAIL drain_noread: got %h expected 0", ed0); end
    step();
    ren0 = 1'b1; #1;
    checks++;
    if (ed0 !== table_v[1]) begin errors++; $display("FAIL drain_regrant: got %h expected %h", ed0, table_v[1]); end
    for (int i = 0; i < 24; i++) begin
      ren0 = 1'($urandom % 2);
      off0 = 2'($urandom % 4);
      #1;
      e = ren0 ? exp_burst(16'h0000, m_gbase0, int'(off0)) : 64'd0;
      checks++;
      if (ed0 !== e || rdy0 !== 1'b1) begin
        errors++; $display("FAIL rand_burst ren=%b off=%0d: got %h rdy %b expected %h rdy 1",
                           ren0, off0, ed0, rdy0, e);
      end
      $display("rand ren=%b off=%0d edata %h", ren0, off0, ed0);
      step();
    end
  endtask

  task automatic test_dma_end();
    logic [63:0] e;
    ren0 = 1'b1; off0 = 2'd0; dend0 = 1'b1;
    step();
    dend0 = 1'b0;
    m_xfer0 = m_xfer0 + 8'd1;
    m_gbase0 = m_gbase0 + 16'd12;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL dma_end_ready: got %b expected 0", rdy0); end
    checks++; if (xc0 !== m_xfer0) begin errors++; $display("FAIL dma_end_xfer: got %0d expected %0d", xc0, m_xfer0); end
    checks++; if (ed0 !== 64'd0) begin errors++; $display("FAIL fill_read_edata: got %h expected 0", ed0); end
    wait_ready(0, 48, $urandom_range(5, 40), "second_fill");
    checks++; if (xc0 !== m_xfer0) begin errors++; $display("FAIL fill_dma_ignored: got %0d expected %0d", xc0, m_xfer0); end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq2: got %b expected 1", irq0); end
    e = exp_burst(16'h0000, m_gbase0, 0);
    checks++;
    if (ed0 !== 64'h000F_000E_000D_000C || ed0 !== e) begin
      errors++; $display("FAIL block2_off0: got %h expected %h", ed0, e);
    end
    $display("block 2 offset 0 edata %h xfer %0d", ed0, xc0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int o;
    ren0 = 1'b1; dend0 = 1'b1;
    step();
    dend0 = 1'b0;
    m_xfer0 = m_xfer0 + 8'd1;
    m_gbase0 = m_gbase0 + 16'd12;
    checks++;
    if (rdy0 !== 1'b0 || xc0 !== m_xfer0) begin
      errors++; $display("FAIL simul_end_read: rdy %b xfer %0d expected rdy 0 xfer %0d", rdy0, xc0, m_xfer0);
    end
    wait_ready(0, 48, 0, "third_fill");
    o = int'($urandom % 3);
    off0 = 2'(o);
    #1;
    e = exp_burst(16'h0000, m_gbase0, o);
    checks++;
    if (ed0 !== e) begin errors++; $display("FAIL block3 off=%0d: got %h expected %h", o, ed0, e); end
    $display("block 3 offset %0d edata %h", o, ed0);
  endtask

  task automatic test_reset_mid();
    dend0 = 1'b1;
    step();
    dend0 = 1'b0;
    repeat (30) step();
    ren0 = 1'b1; off0 = 2'd0;
    rst0 = 1'b1;
    #1;
    checks++;
    if (ed0 !== 64'd0 || irq0 !== 1'b0 || rdy0 !== 1'b0 || xc0 !== 8'd0) begin
      errors++; $display("FAIL reset_in_fill: edata %h irq %b rdy %b xfer %0d expected all 0", ed0, irq0, rdy0, xc0);
    end
    step();
    rst0 = 1'b0;
    m_gbase0 = 16'd0;
    m_xfer0  = 8'd0;
    #1;
    checks++; if (ed0 !== 64'd0) begin errors++; $display("FAIL stale_buffer: got %h expected 0", ed0); end
    wait_ready(0, 48, 0, "refill_after_reset");
    checks++;
    if (ed0 !== 64'h0003_0002_0001_0000) begin
      errors++; $display("FAIL post_reset_off0: got %h expected 0003000200010000", ed0);
    end
    step(); step();
    rst0 = 1'b1;
    #1;
    checks++;
    if (ed0 !== 64'd0 || irq0 !== 1'b0 || rdy0 !== 1'b0 || xc0 !== 8'd0) begin
      errors++; $display("FAIL reset_in_drain: edata %h irq %b rdy %b xfer %0d expected all 0", ed0, irq0, rdy0, xc0);
    end
    step();
    rst0 = 1'b0; ren0 = 1'b0;
    $display("mid-operation resets done");
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    step();
    rst1 = 1'b0;
    m_gbase1 = 16'd0;
    wait_ready(1, 48, $urandom_range(10, 40), "wrap_fill");
    checks++; if (xc1 !== 8'd0) begin errors++; $display("FAIL wrap_dma_ignored: got %0d expected 0", xc1); end
    ren1 = 1'b1; off1 = 2'd0;
    #1;
    checks++;
    if (ed1 !== 64'h0001_0000_FFFF_FFFE) begin
      errors++; $display("FAIL wrap_off0: got %h expected 00010000FFFFFFFE", ed1);
    end
    for (int o = 1; o < 4; o++) begin
      off1 = 2'(o);
      #1;
      e = exp_burst(16'hFFFE, m_gbase1, o);
      checks++;
      if (ed1 !== e) begin errors++; $display("FAIL wrap_off%0d: got %h expected %h", o, ed1, e); end
      $display("wrap offset %0d edata %h", o, ed1);
    end
  endtask

  initial begin
    rst0 = 1'b1; ren0 = 1'b0; off0 = 2'd0; dend0 = 1'b0;
    rst1 = 1'b1; ren1 = 1'b0; off1 = 2'd0; dend1 = 1'b0;
    test_reset();
    test_fill_timing();
    test_bursts();
    test_dma_end();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ext_device.md
# ext_device

Behavioural/synthesizable model of the external I/O device that sits directly upstream of the DMA controller. It generates a 12-word block of 16-bit data into an internal buffer at a fixed rate and pulses an interrupt to the CPU when the block is complete. It then serves the block to the DMA engine as 4-word bursts selected by the DMA's burst offset. It re-arms when the DMA signals end of transfer.

## Interface
- WORD_SIZE, 16: data word width
- LENGTH, 12: words per block; must be a multiple of 4
- FILL_INTERVAL, 4: clock cycles per generated word; must be ≥ 1
- DATA_BASE, 16'h0000: value added to the global word index to form each word

- CLK  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- read_en  input  1  DMA is on the bus and writing memory; driven by the DMA WRITE signal
- offset  input  2  burst index from the DMA, 0..LENGTH/4-1
- dma_end  input  1  DMA end-of-transfer indication; driven by the DMA interrupt
- edata  output  4*WORD_SIZE  current 4-word burst
- dev_interrupt  output  1  one-cycle pulse: block ready for DMA
- ready  output  1  block held and available (READY or DRAIN)
- xfer_count  output  8  count of completed blocks; wraps 255→0

## Operation
- Registers:
  - buffer[0..LENGTH-1] (WORD_SIZE each)
  - word_idx: 0..LENGTH
  - interval counter: 0..FILL_INTERVAL-1
  - global word counter gcount: 16 bits, wraps
  - state
  - xfer_count
- States: FILL, READY, DRAIN.
- **FILL**
  - Interval counter increments each posedge.
  - When it equals FILL_INTERVAL-1:
    - buffer[word_idx] ← DATA_BASE + gcount (16-bit wrap)
    - gcount++, word_idx++, interval counter ← 0
  - The posedge that writes word LENGTH-1 also moves state to READY.
- **READY**: holds the buffer. On a posedge with read_en=1, moves to DRAIN.
- **DRAIN**: holds the buffer. read_en may drop and rise again (bus regranted); the state remains DRAIN.
- **dma_end=1** at a posedge in READY or DRAIN:
  - state ← FILL, word_idx ← 0, interval counter ← 0
  - xfer_count++
  - Buffer contents are kept until overwritten.
- dma_end in FILL is ignored.
- **edata**, combinational:
  - When read_en=1, state ≠ FILL, and offset < LENGTH/4: {buffer[4·offset+3], buffer[4·offset+2], buffer[4·offset+1], buffer[4·offset]}, with the lowest-addressed word in bits [15:0].
  - Otherwise 0. This includes offset=3 with LENGTH=12.
- **dev_interrupt**: high for exactly the one cycle following the FILL→READY transition; registered.
- **ready**: 1 in READY or DRAIN.
- read_en during FILL has no effect and edata stays 0.

## Timing
- Reset values:
  - Outputs: edata=0, dev_interrupt=0, ready=0, xfer_count=0
  - Internal: state=FILL, word_idx=0, interval counter=0, gcount=0
- Reset mid-operation, in any state: immediate return to the reset values. The buffer may be left uncleared but is never presented until refilled.
- Posedges are numbered from the first posedge after reset deasserts (= 1).
- Word j of a block is written at posedge (j+1)·FILL_INTERVAL after entering FILL. With defaults, word 11 is written at posedge 48.
- ready and dev_interrupt rise after posedge 48. dev_interrupt falls after posedge 49.
- edata follows offset and read_en combinationally with zero-cycle latency, so the DMA samples a stable burst at its address/offset update edges.
- After dma_end is sampled, ready falls and refill starts the next cycle. The next block's word 0 is written FILL_INTERVAL posedges later.
- Simultaneous read_en and dma_end in READY: dma_end wins and the state goes to FILL.

## Test plan
- Reset release, defaults, read_en=0 → ready=0 through posedge 47; dev_interrupt=1 for exactly the cycle after posedge 48; ready=1 from posedge 48.
- After ready, read_en=1 with offset 0, 1, 2 → edata = 64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004, 64'h000B_000A_0009_0008; offset=3 → edata=0.
- read_en=0 while ready=1 → edata=0. Toggle read_en 1→0→1 → same bursts, state stays DRAIN.
- Pulse dma_end one cycle → ready=0 next cycle, xfer_count=1. Second block ready 48 posedges later; offset 0 burst = 64'h000F_000E_000D_000C.
- Assert reset at posedge 30 of fill, and separately in DRAIN → all outputs return to 0 asynchronously. Next block starts at gcount 0: offset 0 burst = 64'h0003_0002_0001_0000 again.
- DATA_BASE=16'hFFFE, read_en=1 after ready → offset 0 burst = 64'h0001_0000_FFFF_FFFE (wrap). dma_end pulsed during FILL → ignored, xfer_count unchanged.
